// File: rtl/regfile.sv
// 32 x DATA_WIDTH register file: two mux-tree read ports, one write port.
// Optional write-through bypass on both read ports: define REGFILE_BYPASS_EN.
module mux_2x1 #(
  parameter int W = 1
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sel_i,
  output logic [W-1:0] y_o
);
  assign y_o = sel_i ? b_i : a_i;
endmodule

module mux_4x1 #(
  parameter int W = 1
) (
  input  logic [W-1:0] in0_i,
  input  logic [W-1:0] in1_i,
  input  logic [W-1:0] in2_i,
  input  logic [W-1:0] in3_i,
  input  logic [1:0]   sel_i,
  output logic [W-1:0] y_o
);
  always_comb begin
    y_o = in0_i;
    unique case (sel_i)
      2'd0: y_o = in0_i;
      2'd1: y_o = in1_i;
      2'd2: y_o = in2_i;
      2'd3: y_o = in3_i;
    endcase
  end
endmodule

module regfile_rd_tree #(
  parameter int W = 64
) (
  input  logic [31:0][W-1:0] row_i,
  input  logic [4:0]         addr_i,
  output logic [W-1:0]       data_o
);
  logic [7:0][W-1:0] l1;
  logic [1:0][W-1:0] l2;

  for (genvar g = 0; g < 8; g++) begin : g_l1
    mux_4x1 #(.W(W)) u_mux (
      .in0_i (row_i[4*g]),
      .in1_i (row_i[4*g+1]),
      .in2_i (row_i[4*g+2]),
      .in3_i (row_i[4*g+3]),
      .sel_i (addr_i[1:0]),
      .y_o   (l1[g])
    );
  end

  for (genvar g = 0; g < 2; g++) begin : g_l2
    mux_4x1 #(.W(W)) u_mux (
      .in0_i (l1[4*g]),
      .in1_i (l1[4*g+1]),
      .in2_i (l1[4*g+2]),
      .in3_i (l1[4*g+3]),
      .sel_i (addr_i[3:2]),
      .y_o   (l2[g])
    );
  end

  mux_2x1 #(.W(W)) u_l3 (
    .a_i   (l2[0]),
    .b_i   (l2[1]),
    .sel_i (addr_i[4]),
    .y_o   (data_o)
  );
endmodule

module regfile #(
  parameter int DATA_WIDTH = 64,
  parameter int ZERO_REG   = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [4:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [4:0]            rd_addr1,
  input  logic [4:0]            rd_addr2,
  output logic [DATA_WIDTH-1:0] rd_data1,
  output logic [DATA_WIDTH-1:0] rd_data2
);
  localparam logic [4:0] ZIDX = 5'(ZERO_REG);

  logic [31:0]                 load;
  logic [31:0][DATA_WIDTH-1:0] row;
  logic [DATA_WIDTH-1:0]       tree1;
  logic [DATA_WIDTH-1:0]       tree2;

  assign load = wr_en ? (32'd1 << wr_addr) : 32'd0;

  for (genvar i = 0; i < 32; i++) begin : g_reg
    if (i == ZERO_REG) begin : g_zero
      assign row[i] = '0;
    end else begin : g_ff
      logic [DATA_WIDTH-1:0] rf_q;
      logic [DATA_WIDTH-1:0] rf_d;
      assign rf_d = load[i] ? wr_data : rf_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) rf_q <= '0;
        else       rf_q <= rf_d;
      end
      assign row[i] = rf_q;
    end
  end

  regfile_rd_tree #(.W(DATA_WIDTH)) u_rd1 (
    .row_i  (row),
    .addr_i (rd_addr1),
    .data_o (tree1)
  );

  regfile_rd_tree #(.W(DATA_WIDTH)) u_rd2 (
    .row_i  (row),
    .addr_i (rd_addr2),
    .data_o (tree2)
  );

`ifdef REGFILE_BYPASS_EN
  logic byp_ok;
  assign byp_ok   = wr_en && !reset && (wr_addr != ZIDX);
  assign rd_data1 = (byp_ok && wr_addr == rd_addr1) ? wr_data : tree1;
  assign rd_data2 = (byp_ok && wr_addr == rd_addr2) ? wr_data : tree2;
`else
  assign rd_data1 = tree1;
  assign rd_data2 = tree2;
`endif
endmodule
